load_store_unit: RTL

Multi-cycle load/store unit placed between the core datapath and data memory, generalised from the single-cycle byte-lane logic to XLEN 32 or 64. Accepts one memory request at a time over a valid/ready handshake and drives a memory port that tolerates wait states. Handles sign/zero extension and byte-lane steering, and splits word-crossing misaligned accesses into two beats, or faults them when splitting is disabled.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit with lane steering and misaligned split
module load_store_unit #(
    parameter int XLEN               = 32,
    parameter int SUPPORT_MISALIGNED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int LW = 2 * NB;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
    state_t state, state_next;

    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata0_q;
    logic [XLEN-1:0] rdata1_q;
    logic            fault_q;

    logic [3:0]      req_size;
    logic [OW-1:0]   req_size_m1;
    logic            req_illegal;
    logic            req_fault;

    // Classify the incoming request: illegal encodings and, without split support, any misalignment
    always_comb begin
        req_size    = 4'd1 << req_funct3[1:0];
        req_size_m1 = OW'(req_size - 4'd1);
        if (req_is_store) begin
            req_illegal = req_funct3[2] || (XLEN == 32 && req_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (req_funct3 == 3'b111) ||
                          (XLEN == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
        end
        req_fault = req_illegal ||
                    (SUPPORT_MISALIGNED == 0 && (req_addr[OW-1:0] & req_size_m1) != '0);
    end

    logic [3:0]      size;
    logic [OW-1:0]   off;
    logic [4:0]      span;
    logic            split;
    logic [OW+2:0]   shamt;
    logic [LW-1:0]   lanes;
    logic [XLEN-1:0] wrot;
    logic [XLEN-1:0] wbeat0;
    logic [XLEN-1:0] wbeat1;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] lowmask;
    logic [XLEN-1:0] load_ext;
    logic [6:0]      nbits;
    logic            sign;
    logic [XLEN-1:0] base_addr;

    // Lane steering for writes and little-endian assembly/extension for reads, from latched operands
    always_comb begin
        size   = 4'd1 << funct3_q[1:0];
        off    = addr_q[OW-1:0];
        span   = 5'(off) + 5'(size);
        split  = span > 5'(NB);
        shamt  = {off, 3'b000};
        // Byte enables over a two-word window; low half is beat 0, high half is beat 1
        lanes  = ((LW'(1) << size) - LW'(1)) << off;
        wrot   = XLEN'(({wdata_q, wdata_q} << shamt) >> XLEN);
        wbeat0 = '0;
        wbeat1 = '0;
        for (int i = 0; i < NB; i++) begin
            wbeat0[8*i +: 8] = lanes[i]      ? wrot[8*i +: 8] : 8'h00;
            wbeat1[8*i +: 8] = lanes[NB + i] ? wrot[8*i +: 8] : 8'h00;
        end
        raw      = XLEN'({rdata1_q, rdata0_q} >> shamt);
        nbits    = {size, 3'b000};
        lowmask  = (int'(nbits) >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        sign     = |(raw & (XLEN'(1) << (nbits - 7'd1)));
        load_ext = (raw & lowmask) | ((sign && !funct3_q[2]) ? ~lowmask : '0);
        base_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};
    end

    // State register; reset aborts any beat in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and all outputs; every output is a pure function of state and latched operands
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_fault    = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_fault ? RESP : REQ0;
            end
            REQ0: begin
                mem_req_valid = 1'b1;
                mem_we        = is_store_q;
                mem_addr      = base_addr;
                if (is_store_q) begin
                    mem_wdata = wbeat0;
                    mem_wmask = lanes[NB-1:0];
                end
                if (mem_req_ready) begin
                    if (!is_store_q) state_next = WAIT0;
                    else             state_next = split ? REQ1 : RESP;
                end
            end
            WAIT0: begin
                if (mem_rvalid) state_next = split ? REQ1 : RESP;
            end
            REQ1: begin
                mem_req_valid = 1'b1;
                mem_we        = is_store_q;
                mem_addr      = base_addr + XLEN'(NB);
                if (is_store_q) begin
                    mem_wdata = wbeat1;
                    mem_wmask = lanes[LW-1:NB];
                end
                if (mem_req_ready) state_next = is_store_q ? RESP : WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = (fault_q || is_store_q) ? '0 : load_ext;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch on accept and read-data capture per beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fault_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                is_store_q <= req_is_store;
                funct3_q   <= req_funct3;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                fault_q    <= req_fault;
            end
            if (state == WAIT0 && mem_rvalid) rdata0_q <= mem_rdata;
            if (state == WAIT1 && mem_rvalid) rdata1_q <= mem_rdata;
        end
    end
endmodule
